ram8_arbiter: RTL and testbench
===============================

Name: ram8_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the 8x16 single-port RAM (RAM8_16bit).
- Each requester issues single-word read or write commands with a req/gnt handshake.
- The block drives the RAM strobes and address/data, and returns read data with a one-cycle valid pulse.
- Sits between CPU-side masters and RAM8_16bit; the RAM is never driven directly by the requesters.

Parameters:
- DW, 16, data width (matches RAM word).
- AW, 3, address width (8 words).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- req0/req1  in  1  requester command request
- we0/we1  in  1  1 = write, 0 = read; stable while req high
- addr0/addr1  in  AW  word address; stable while req high
- wdata0/wdata1  in  DW  write data; stable while req high
- gnt0/gnt1  out  1  one-cycle grant pulse; command accepted
- rvalid0/rvalid1  out  1  one-cycle read-data-valid pulse
- rdata0/rdata1  out  DW  read data; held until next read completes for that port
- ram_en  out  1  RAM enable
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_add  out  AW  RAM address
- ram_in  out  DW  RAM write data
- ram_out  in  DW  RAM read data; registered by RAM, valid the cycle after en&read

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE. gnt*, rvalid*, ram_en, ram_read and ram_write are 0. rdata*, ram_add and ram_in are 0. Last-grant pointer=1, so req0 wins the first tie.
- FSM states: IDLE, ISSUE, CAPT.
- IDLE, no req: stay.
- IDLE, any req: pick the winner. If only one requests, that one wins. If both request, the port not last granted wins. On that edge:
  - latch winner's we/addr/wdata into the command registers;
  - set gnt_winner=1 and update the pointer;
  - go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ram_en=1, ram_add/ram_in from the command registers;
  - ram_write=we, ram_read=~we;
  - gnt_winner high for this cycle only.
  - Next edge: write goes to IDLE; read goes to CAPT.
- CAPT (exactly 1 cycle): all RAM strobes 0. Next edge: rdata_winner<=ram_out, rvalid_winner=1 for one cycle, go to IDLE.
- Latency:
  - Write: gnt 1 cycle after req is sampled; RAM written at end of ISSUE.
  - Read: rvalid 3 cycles after the req-sample edge.
- Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Handshake:
  - A requester must hold req/we/addr/wdata until it samples gnt=1, then deassert req or present the next command.
  - req still high in IDLE after a completed transaction is a new command.
- The losing requester keeps waiting. Round-robin guarantees it wins the next arbitration, so neither port can starve.
- RAM strobes are never asserted outside ISSUE. Only one of ram_read/ram_write is ever high.
- rvalid and gnt never assert in the same cycle for the same port.
- Address wrap: none; AW bits are passed through unchanged.
- Reset mid-operation: the pending command is dropped, no gnt/rvalid is issued, and strobes drop on the reset edge.

Optional Feature:
- Macro RAM8_ARB_STATS_EN.
- Defined: adds output port conflict_cnt (8 bits). It increments at each IDLE edge where req0 and req1 are both 1, saturates at 255, and is cleared by reset.
- Undefined: no port, no counter logic.

Test Plan:
- Write only on port 0: req0, we0=1, addr0=3, wdata0=16'h00A5 -> gnt0 1 cycle later; ram_en=ram_write=1, ram_add=3, ram_in=A5 for exactly 1 cycle.
- Read-back on port 1 after that write: req1, we1=0, addr1=3 -> gnt1, then rvalid1 pulse with rdata1=16'h00A5 3 cycles after the sample edge; rdata1 holds A5 afterward.
- Simultaneous requests held continuously: req0 and req1 both held writing addr 0..7 with data 1..8 -> gnt alternates 0,1,0,1...; first grant goes to port 0; all 8 locations read back correct.
- Reset during ISSUE of a read: rst_n=0 -> strobes 0 on the reset edge, no rvalid, state IDLE, pointer=1.
- Idle bus: no requests for 20 cycles -> all outputs 0, RAM strobes never asserted.
- With RAM8_ARB_STATS_EN: 300 tie arbitrations -> conflict_cnt=255 (saturated).

Source files
------------

// File: rtl/ram8_arbiter_if.sv
// ram8_arbiter_if: bundles both requester channels and the RAM-side strobes of ram8_arbiter.
// Ports: req/we/addr/wdata (requester -> arbiter), gnt/rvalid/rdata (arbiter -> requester),
//        ram_en/ram_read/ram_write/ram_add/ram_in (arbiter -> RAM), ram_out (RAM -> arbiter).
interface ram8_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  // requester 0
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;
  // requester 1
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;
  // RAM side
  logic          ram_en;
  logic          ram_read;
  logic          ram_write;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out;

  // master: the requesters plus the RAM (everything outside the arbiter)
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_en, ram_read, ram_write, ram_add, ram_in,
    output ram_out
  );

  // slave: the arbiter itself
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_en, ram_read, ram_write, ram_add, ram_in,
    input  ram_out
  );
endinterface

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: two-requester round-robin arbiter/sequencer in front of an 8x16 single-port RAM.
// Ports: clk, rst_n (synchronous, active low), bus (ram8_arbiter_if.slave), and conflict_cnt[7:0]
//        only when RAM8_ARB_STATS_EN is defined (saturating count of tied arbitrations).
// Timing: gnt during the cycle after the sample edge; write 2 cycles/op, read rvalid 3 cycles after sample.
module ram8_arbiter #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  ram8_arbiter_if.slave bus
`ifdef RAM8_ARB_STATS_EN
  ,
  output logic [7:0]    conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Command registers: loaded on the arbitration edge, consumed in ISSUE/CAPT.
  logic          cmd_port;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  // Port granted most recently; reset to 1 so port 0 wins the first tie.
  logic          last;

  logic          any_req;
  logic          both_req;
  logic          win;
  logic          take;
  logic          capture;

  logic          ram_en_c;
  logic          ram_read_c;
  logic          ram_write_c;
  logic [AW-1:0] ram_add_c;
  logic [DW-1:0] ram_in_c;

  logic          rvalid0_q;
  logic          rvalid1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  assign any_req  = bus.req0 | bus.req1;
  assign both_req = bus.req0 & bus.req1;
  // On a tie the port not granted last time wins; otherwise the sole requester wins.
  assign win      = both_req ? ~last : bus.req1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and RAM strobes
  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    capture     = 1'b0;
    ram_en_c    = 1'b0;
    ram_read_c  = 1'b0;
    ram_write_c = 1'b0;
    ram_add_c   = '0;
    ram_in_c    = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ram_en_c    = 1'b1;
        ram_write_c = cmd_we;
        ram_read_c  = ~cmd_we;
        ram_add_c   = cmd_addr;
        ram_in_c    = cmd_wdata;
        // The RAM registers read data at the end of ISSUE, so reads need a capture cycle.
        state_nxt   = cmd_we ? IDLE : CAPT;
      end
      CAPT: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command latch, round-robin pointer and read-data return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      last      <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      if (take) begin
        cmd_port  <= win;
        last      <= win;
        cmd_we    <= win ? bus.we1    : bus.we0;
        cmd_addr  <= win ? bus.addr1  : bus.addr0;
        cmd_wdata <= win ? bus.wdata1 : bus.wdata0;
      end
      if (capture) begin
        if (cmd_port) begin
          rdata1_q  <= bus.ram_out;
          rvalid1_q <= 1'b1;
        end else begin
          rdata0_q  <= bus.ram_out;
          rvalid0_q <= 1'b1;
        end
      end
    end
  end

  // The grant is the ISSUE cycle itself, so it is exactly one cycle long and
  // drops with the state on a reset edge.
  assign bus.gnt0      = (state == ISSUE) & ~cmd_port;
  assign bus.gnt1      = (state == ISSUE) &  cmd_port;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.ram_en    = ram_en_c;
  assign bus.ram_read  = ram_read_c;
  assign bus.ram_write = ram_write_c;
  assign bus.ram_add   = ram_add_c;
  assign bus.ram_in    = ram_in_c;

`ifdef RAM8_ARB_STATS_EN
  // Counts IDLE edges where both ports request; saturates at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt <= 8'd0;
    end else if ((state == IDLE) && both_req && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram8_arbiter.sv
module tb_ram8_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ram8_arbiter_if #(.DW(16), .AW(3)) bus ();

`ifdef RAM8_ARB_STATS_EN
  logic [7:0] conflict_cnt;
`endif

  ram8_arbiter #(.DW(16), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RAM8_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM8_16bit: registered read, write at the clock edge.
  logic [15:0] mem [8];
  always @(posedge clk) begin
    if (!rst_n) bus.ram_out <= '0;
    else if (bus.ram_en && bus.ram_read) bus.ram_out <= mem[bus.ram_add];
    if (bus.ram_en && bus.ram_write) mem[bus.ram_add] <= bus.ram_in;
  end

  // Reference model state
  logic [15:0] ref_mem [8];
  logic [15:0] exp_rdata [2];
  bit          exp_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit r, input bit we, input logic [2:0] a, input logic [15:0] d);
    if (p) begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  function automatic logic get_gnt(input bit p);
    return p ? bus.gnt1 : bus.gnt0;
  endfunction

  function automatic logic get_rvalid(input bit p);
    return p ? bus.rvalid1 : bus.rvalid0;
  endfunction

  function automatic logic [15:0] get_rdata(input bit p);
    return p ? bus.rdata1 : bus.rdata0;
  endfunction

  function automatic logic [31:0] all_outs();
    return {28'd0, bus.gnt0 | bus.gnt1, bus.rvalid0 | bus.rvalid1,
            bus.ram_en | bus.ram_read | bus.ram_write,
            (|bus.ram_add) | (|bus.ram_in) | (|bus.rdata0) | (|bus.rdata1)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) tick();
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    exp_last     = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // One isolated command from port p, checked cycle by cycle against the rules.
  task automatic single_op(input bit p, input bit we, input logic [2:0] a, input logic [15:0] d);
    drive(p, 1, we, a, d);
    tick();
    check("gnt", get_gnt(p), 1);
    check("gnt_other", get_gnt(!p), 0);
    check("rvalid_with_gnt", get_rvalid(p), 0);
    check("ram_en", bus.ram_en, 1);
    check("ram_write", bus.ram_write, we);
    check("ram_read", bus.ram_read, !we);
    check("ram_add", bus.ram_add, a);
    check("ram_in", bus.ram_in, d);
    drive(p, 0, 0, 0, 0);
    exp_last = p;
    tick();
    check("strobes_after_issue", {bus.ram_en, bus.ram_read, bus.ram_write}, 0);
    check("gnt_pulse", get_gnt(p), 0);
    if (we) begin
      ref_mem[a] = d;
    end else begin
      check("rvalid_early", get_rvalid(p), 0);
      tick();
      exp_rdata[p] = ref_mem[a];
      check("rvalid", get_rvalid(p), 1);
      check("rvalid_other", get_rvalid(!p), 0);
      check("rdata", get_rdata(p), exp_rdata[p]);
      tick();
      check("rvalid_pulse", get_rvalid(p), 0);
    end
    check("rdata0_hold", bus.rdata0, exp_rdata[0]);
    check("rdata1_hold", bus.rdata1, exp_rdata[1]);
  endtask

  initial begin
    int i0, i1, cyc, n;
    bit obs, expw, pend0, pend1;
    logic [2:0]  a;
    logic [15:0] d;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Reset state, then an idle bus
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_outputs", all_outs(), 0);
    end

    // Write on port 0, read back on port 1
    single_op(0, 1, 3'd3, 16'h00A5);
    single_op(1, 0, 3'd3, 16'h1234);
    check("rdata1_a5", bus.rdata1, 16'h00A5);

    // Fill the RAM so every later read has a known model value
    for (int k = 0; k < 8; k++) begin
      a = k[2:0];
      single_op(k[0], 1, a, 16'($urandom));
    end

    // Random isolated commands on either port
    for (int k = 0; k < 40; k++) begin
      single_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 16'($urandom));
    end

    // Both ports held: writes addr k with data k+1, port 0 even, port 1 odd
    do_reset();
    i0 = 0;
    i1 = 0;
    cyc = 0;
    drive(0, 1, 1, 3'd0, 16'd1);
    drive(1, 1, 1, 3'd1, 16'd2);
    while ((i0 < 4 || i1 < 4) && cyc < 100) begin
      tick();
      cyc++;
      check("no_double_gnt", bus.gnt0 & bus.gnt1, 0);
      if (bus.gnt0 | bus.gnt1) begin
        obs   = bus.gnt1;
        pend0 = (i0 < 4);
        pend1 = (i1 < 4);
        expw  = (pend0 && pend1) ? !exp_last : pend1;
        check("rr_winner", obs, expw);
        exp_last = obs;
        if (!obs) begin
          a = 3'(2 * i0);
          d = 16'(2 * i0 + 1);
          i0++;
          if (i0 < 4) drive(0, 1, 1, 3'(2 * i0), 16'(2 * i0 + 1));
          else        drive(0, 0, 0, 0, 0);
        end else begin
          a = 3'(2 * i1 + 1);
          d = 16'(2 * i1 + 2);
          i1++;
          if (i1 < 4) drive(1, 1, 1, 3'(2 * i1 + 1), 16'(2 * i1 + 2));
          else        drive(1, 0, 0, 0, 0);
        end
        check("held_ram_add", bus.ram_add, a);
        check("held_ram_in", bus.ram_in, d);
        check("held_ram_write", bus.ram_write, 1);
        ref_mem[a] = d;
      end
    end
    check("held_done", {i0[3:0], i1[3:0]}, 8'h44);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();
`ifdef RAM8_ARB_STATS_EN
    check("conflict_cnt_held", conflict_cnt, 7);
`endif
    for (int k = 0; k < 8; k++) begin
      a = k[2:0];
      single_op(1'($urandom_range(0, 1)), 0, a, 16'($urandom));
    end

    // Reset during ISSUE of a read
    drive(0, 1, 0, 3'd5, 16'h0);
    tick();
    check("pre_reset_gnt", bus.gnt0, 1);
    check("pre_reset_read", bus.ram_read, 1);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    check("reset_edge_strobes", {bus.ram_en, bus.ram_read, bus.ram_write}, 0);
    check("reset_edge_gnt", bus.gnt0 | bus.gnt1, 0);
    rst_n = 1'b1;
    exp_last     = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("no_rvalid_after_reset", bus.rvalid0 | bus.rvalid1, 0);
      check("rdata0_cleared", bus.rdata0, 0);
    end
    // Pointer is back to 1: a tie goes to port 0 first, then port 1
    drive(0, 1, 1, 3'd2, ref_mem[2]);
    drive(1, 1, 1, 3'd4, ref_mem[4]);
    tick();
    check("tie_after_reset_p0", bus.gnt0, 1);
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("tie_after_reset_p1", bus.gnt1, 1);
    drive(1, 0, 0, 0, 0);
    tick();

`ifdef RAM8_ARB_STATS_EN
    // 300 tied arbitrations saturate the conflict counter
    do_reset();
    drive(0, 1, 1, 3'd0, ref_mem[0]);
    drive(1, 1, 1, 3'd1, ref_mem[1]);
    n = 0;
    cyc = 0;
    while (n < 300 && cyc < 2000) begin
      tick();
      cyc++;
      if (bus.gnt0 | bus.gnt1) begin
        n++;
        if (n == 100) check("conflict_cnt_100", conflict_cnt, 100);
      end
    end
    check("tie_grants", n, 300);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();
    tick();
    check("conflict_cnt_sat", conflict_cnt, 255);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
